uart_tx_dev: RTL and testbench

UART_TX_DEV -- requirements
Module: uart_tx_dev

---
 rtl/uart_tx_dev.sv | 271 +++++++++++++++++++++++++++
 tb/tb_uart_tx_dev.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_dev.sv
// Generic single-clock FIFO: byte-wide (parameterised) storage with valid/ready on both sides.
// Latency: a pushed entry is visible on rd_dat the cycle after the push edge.
// Backpressure: wr_rdy drops when full unless a pop is accepted in the same cycle.
module fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [DW-1:0]            wr_dat,
    output logic                     rd_vld,
    input  logic                     rd_rdy,
    output logic [DW-1:0]            rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign rd_vld  = (count != '0);
    assign do_pop  = rd_vld && rd_rdy;
    assign wr_rdy  = (count != CNT_FULL) || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = mem[rd_ptr];

    // Storage array needs no reset; only pointers and count define validity.
    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (!do_push && do_pop) begin
                count <= count - CNT_ONE;
            end
        end
    end
endmodule

// UART transmitter with register bridge: DATA/STATUS/CTRL/DIVISOR, byte FIFO, 8N1 serialiser.
// Latency: a byte written with EN=1 starts its START bit one cycle after the write edge.
// Backpressure: writes to a full FIFO are dropped and flagged in STATUS.OVF.
module uart_tx_dev #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  DevReg,
    input  logic        DevWr,
    input  logic [31:0] DevWD,
    output logic [31:0] DevRD,
    output logic        IRQ,
    output logic        TxD
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   cnt, cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic          fifo_pop;

    logic          en;
    logic          ie;
    logic          ovf;
    logic [15:0]   divisor;
    logic [15:0]   bit_load;
    logic          busy;
    logic          irq_q;

    logic          data_wr;
    logic          fifo_wr_rdy;
    logic          fifo_rd_vld;
    logic [7:0]    fifo_rd_dat;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic [31:0]   status_word;
    logic          unused_wd;

    assign unused_wd = ^DevWD[31:16];

    assign data_wr    = DevWr && (DevReg == REG_DATA);
    assign fifo_empty = !fifo_rd_vld;
    assign fifo_full  = (fifo_count == CNT_FULL);
    assign busy       = (state != IDLE);
    // Divisor 0 behaves as 1; the counter runs from N-1 down to 0.
    assign bit_load   = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);

    fifo #(
        .DW    (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (clk),
        .arst_n   (reset),
        .wr_vld   (data_wr),
        .wr_rdy   (fifo_wr_rdy),
        .wr_dat   (DevWD[7:0]),
        .rd_vld   (fifo_rd_vld),
        .rd_rdy   (fifo_pop),
        .rd_dat   (fifo_rd_dat),
        .count    (fifo_count)
    );

    // Control/config registers; OVF is sticky until software clears it via STATUS bit 3.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            ovf     <= 1'b0;
            divisor <= DIV_RESET;
        end else begin
            if (data_wr && !fifo_wr_rdy) begin
                ovf <= 1'b1;
            end else if (DevWr && (DevReg == REG_STATUS) && DevWD[3]) begin
                ovf <= 1'b0;
            end
            if (DevWr && (DevReg == REG_CTRL)) begin
                en <= DevWD[0];
                ie <= DevWD[1];
            end
            if (DevWr && (DevReg == REG_DIV)) begin
                divisor <= DevWD[15:0];
            end
        end
    end

    // Transmit state and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // Next-state: each bit period lasts bit_load+1 cycles; STOP chains straight into START.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        fifo_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (en && fifo_rd_vld) begin
                    state_nxt = START;
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_rd_dat;
                    cnt_nxt   = bit_load;
                end
            end
            START: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    cnt_nxt     = bit_load;
                end
            end
            DATA: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else if (bit_idx == 3'd7) begin
                    state_nxt = STOP;
                    cnt_nxt   = bit_load;
                end else begin
                    shreg_nxt   = {1'b0, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    cnt_nxt     = bit_load;
                end
            end
            STOP: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else if (en && fifo_rd_vld) begin
                    state_nxt = START;
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_rd_dat;
                    cnt_nxt   = bit_load;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line is decoded from state so an async reset returns it high at once.
    always_comb begin
        TxD = 1'b1;
        if (state == START) begin
            TxD = 1'b0;
        end else if (state == DATA) begin
            TxD = shreg[0];
        end
    end

    // Registered interrupt: follows the condition with one cycle of lag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ie && fifo_empty && !busy;
        end
    end

    assign IRQ = irq_q;

    assign status_word = {23'd0, 5'(fifo_count), ovf, fifo_empty, fifo_full, busy};

    // Combinational register read mux.
    always_comb begin
        DevRD = 32'd0;
        case (DevReg)
            REG_DATA:   DevRD = 32'd0;
            REG_STATUS: DevRD = status_word;
            REG_CTRL:   DevRD = {30'd0, ie, en};
            REG_DIV:    DevRD = {16'd0, divisor};
            default:    DevRD = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_dev.sv
module tb_uart_tx_dev;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  DevReg;
    logic        DevWr;
    logic [31:0] DevWD;
    logic [31:0] DevRD;
    logic        IRQ;
    logic        TxD;

    always #5 clk = ~clk;

    uart_tx_dev #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (16'd16)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .DevReg (DevReg),
        .DevWr  (DevWr),
        .DevWD  (DevWD),
        .DevRD  (DevRD),
        .IRQ    (IRQ),
        .TxD    (TxD)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];
    int         starts[$];
    int         cyc         = 0;
    int         frames_done = 0;
    int         mon_n       = 16;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line receiver: checks every cycle of each frame against the expected bit timing.
    initial begin
        bit         m_act = 1'b0;
        bit         m_ok  = 1'b1;
        int         m_pos = 0;
        logic [7:0] m_byte = 8'd0;
        int         slot;
        int         off;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m_act = 1'b0;
            end else begin
                if (!m_act && (TxD === 1'b0)) begin
                    m_act  = 1'b1;
                    m_pos  = 0;
                    m_ok   = 1'b1;
                    m_byte = 8'd0;
                    starts.push_back(cyc);
                end
                if (m_act) begin
                    slot = m_pos / mon_n;
                    off  = m_pos % mon_n;
                    if (slot == 0) begin
                        if (TxD !== 1'b0) m_ok = 1'b0;
                    end else if (slot <= 8) begin
                        if (off == 0) m_byte[slot-1] = TxD;
                        else if (TxD !== m_byte[slot-1]) m_ok = 1'b0;
                    end else begin
                        if (TxD !== 1'b1) m_ok = 1'b0;
                    end
                    if (m_pos == 10*mon_n - 1) begin
                        chk("frame_fmt", 32'(m_ok), 32'd1);
                        chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                        if (sb.size() > 0) chk("frame_byte", 32'(m_byte), 32'(sb.pop_front()));
                        frames_done++;
                        m_act = 1'b0;
                    end else begin
                        m_pos++;
                    end
                end
            end
        end
    end

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        DevReg = a;
        DevWD  = d;
        DevWr  = 1'b1;
        @(posedge clk);
        #1;
        DevWr  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        DevReg = a;
        #1;
        v = DevRD;
    endtask

    task automatic set_div(input logic [15:0] d);
        reg_wr(2'd3, {16'd0, d});
        mon_n = (d == 16'd0) ? 1 : int'(d);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        reg_wr(2'd0, {24'd0, b});
        if (accept) sb.push_back(b);
    endtask

    task automatic wait_frames(input int tgt, input int budget);
        for (int i = 0; i < budget && frames_done < tgt; i++) begin
            @(posedge clk);
            #2;
        end
        chk("frames_done", frames_done, tgt);
    endtask

    initial begin
        logic [31:0] v;
        bit          bad;
        reset  = 1'b0;
        DevReg = 2'd0;
        DevWr  = 1'b0;
        DevWD  = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_txd", 32'(TxD), 32'd1);
        chk("rst_irq", 32'(IRQ), 32'd0);
        rd(2'd0, v); chk("rst_data", v, 32'd0);
        rd(2'd1, v); chk("rst_status", v, 32'h4);
        rd(2'd2, v); chk("rst_ctrl", v, 32'd0);
        rd(2'd3, v); chk("rst_div", v, 32'd16);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, divisor 2
        set_div(16'd2);
        reg_wr(2'd2, 32'd1);
        push_byte(8'hA5, 1'b1);
        wait_frames(1, 200);
        rd(2'd1, v); chk("a5_busy_done", 32'(v[0]), 32'd0);
        chk("a5_txd_idle", 32'(TxD), 32'd1);

        // Overflow, OVF clear, push+pop on full, back-to-back frames
        reg_wr(2'd2, 32'd0);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b0);
        rd(2'd1, v); chk("ovf_status", v, 32'h4A);
        rd(2'd0, v); chk("data_rd_zero", v, 32'd0);
        reg_wr(2'd1, 32'h8);
        rd(2'd1, v); chk("ovf_cleared", v, 32'h42);
        starts.delete();
        reg_wr(2'd2, 32'd1);
        push_byte(8'h66, 1'b1);
        rd(2'd1, v); chk("full_pushpop", v, 32'h43);
        wait_frames(6, 400);
        chk("b2b_frames", starts.size(), 5);
        for (int i = 0; i + 1 < starts.size(); i++) chk("b2b_gap", starts[i+1] - starts[i], 20);
        rd(2'd1, v); chk("b2b_idle_status", v, 32'h4);

        // Interrupt timing
        set_div(16'd1);
        reg_wr(2'd2, 32'd3);
        @(posedge clk);
        #1;
        chk("irq_pre", 32'(IRQ), 32'd1);
        push_byte(8'h5A, 1'b1);
        DevReg = 2'd1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (DevRD[0]) break;
        end
        chk("irq_busy_seen", 32'(DevRD[0]), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!DevRD[0]) break;
            if (IRQ !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("irq_in_frame", 32'(bad), 32'd0);
        chk("irq_idle_lag", 32'(IRQ), 32'd0);
        @(negedge clk);
        chk("irq_idle", 32'(IRQ), 32'd1);
        wait_frames(7, 50);
        reg_wr(2'd2, 32'd1);
        @(negedge clk);
        chk("irq_reg_lag", 32'(IRQ), 32'd1);
        @(negedge clk);
        chk("irq_cleared", 32'(IRQ), 32'd0);

        // Divisor 0 acts as 1: 10-cycle frame
        set_div(16'd0);
        push_byte(8'hFF, 1'b1);
        wait_frames(8, 50);
        rd(2'd1, v); chk("div0_done_status", v, 32'h4);

        // EN cleared during DATA bit 3 with two bytes queued
        set_div(16'd4);
        reg_wr(2'd2, 32'd0);
        push_byte(8'h81, 1'b1);
        push_byte(8'h7E, 1'b1);
        reg_wr(2'd2, 32'd1);
        repeat (17) @(posedge clk);
        #1;
        reg_wr(2'd2, 32'd0);
        wait_frames(9, 100);
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) bad = 1'b1;
        end
        chk("en_off_idle", 32'(bad), 32'd0);
        rd(2'd1, v); chk("en_off_status", v, 32'h10);
        reg_wr(2'd2, 32'd1);
        wait_frames(10, 100);

        // Reset in the middle of a frame
        reg_wr(2'd2, 32'd0);
        push_byte(8'h01, 1'b1);
        push_byte(8'h02, 1'b1);
        push_byte(8'h03, 1'b1);
        push_byte(8'h04, 1'b1);
        reg_wr(2'd2, 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_txd_busy", 32'(TxD === 1'b0 || TxD === 1'b1), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_txd", 32'(TxD), 32'd1);
        chk("midrst_irq", 32'(IRQ), 32'd0);
        rd(2'd1, v); chk("midrst_status", v, 32'h4);
        rd(2'd3, v); chk("midrst_div", v, 32'd16);
        rd(2'd2, v); chk("midrst_ctrl", v, 32'd0);
        sb.delete();
        mon_n = 16;
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("post_rst_txd", 32'(TxD), 32'd1);
        reg_wr(2'd2, 32'd1);
        push_byte(8'hC3, 1'b1);
        wait_frames(11, 220);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
